// File: rtl/pipelined_carry_adder_pkg.sv
// Shared definitions for the pipelined carry adder.
//   OP_ADD / OP_SUB   : encodings of the op input
//   DEFAULT_NUMBITS   : default operand / result width
//   DEFAULT_STAGEBITS : default number of bits added per pipeline stage
package pipelined_carry_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_NUMBITS   = 64;
    localparam int DEFAULT_STAGEBITS = 16;

endpackage : pipelined_carry_adder_pkg

// File: rtl/pipelined_carry_adder_slice_stage.sv
// One pipeline stage of the pipelined carry adder (module adder_slice_stage).
// Adds a STAGEBITS-wide slice with carry-in and registers the slice sum, the
// carry out of the slice, the signed-overflow flag of the slice MSB and the
// stage valid bit. All registers hold while advance is low.
//   clk, reset : clock, asynchronous active-high reset
//   advance    : global pipeline enable (0 = stall, hold everything)
//   valid      : the operands presented this cycle belong to a real operation
//   cin        : carry into bit 0 of the slice
//   a, b       : operand slices (b already inverted for subtract)
//   valid_r    : registered valid
//   cout_r     : registered carry out of the slice MSB
//   ovf_r      : registered signed overflow (only meaningful in the top slice)
//   sum_r      : registered slice sum
module adder_slice_stage #(
    parameter int STAGEBITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 advance,
    input  logic                 valid,
    input  logic                 cin,
    input  logic [STAGEBITS-1:0] a,
    input  logic [STAGEBITS-1:0] b,
    output logic                 valid_r,
    output logic                 cout_r,
    output logic                 ovf_r,
    output logic [STAGEBITS-1:0] sum_r
);

    logic [STAGEBITS:0] full_s;
    logic               msb_cin_s;

    // Slice addition; the carry into the MSB is recovered from the MSB sum bit
    // (sum = a ^ b ^ carry_in), which also works for a one-bit slice.
    always_comb begin
        full_s    = {1'b0, a} + {1'b0, b} + {{STAGEBITS{1'b0}}, cin};
        msb_cin_s = a[STAGEBITS-1] ^ b[STAGEBITS-1] ^ full_s[STAGEBITS-1];
    end

    // Stage output register, frozen while the pipeline is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            sum_r   <= {STAGEBITS{1'b0}};
        end else if (advance) begin
            valid_r <= valid;
            cout_r  <= full_s[STAGEBITS];
            ovf_r   <= full_s[STAGEBITS] ^ msb_cin_s;
            sum_r   <= full_s[STAGEBITS-1:0];
        end
    end

endmodule : adder_slice_stage

// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract unit, STAGEBITS bits per stage, valid/ready on both
// sides, one operation per cycle, latency NSTAGES = NUMBITS/STAGEBITS cycles.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (A, B, op sampled on acceptance)
//   A, B                : operands
//   op                  : 0 = A+B, 1 = A-B
//   out_valid/out_ready : output handshake
//   result              : sum / difference modulo 2^NUMBITS
//   carryout            : carry out of MSB (subtract: 1 = no borrow)
//   overflow            : signed two's-complement overflow
// Structure: an input capture register feeds stage 0 directly; slice k of the
// operands travels through k extra skew registers so it meets the carry of
// stage k-1. Finished lower result slices ride through deskew registers so the
// whole result leaves the last stage together. A single advance signal stalls
// every register at once, so bubbles are never collapsed.
module pipelined_carry_adder
    import pipelined_carry_adder_pkg::*;
#(
    parameter int NUMBITS   = DEFAULT_NUMBITS,
    parameter int STAGEBITS = DEFAULT_STAGEBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic               op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               carryout,
    output logic               overflow
);

    localparam int NSTAGES = NUMBITS / STAGEBITS;

    if ((NSTAGES < 1) || ((NUMBITS % STAGEBITS) != 0)) begin : g_bad_params
        $error("NUMBITS must be a non-zero multiple of STAGEBITS");
    end

    logic               advance_s;
    logic [NUMBITS-1:0] b_eff_s;

    logic               in_valid_r;
    logic [NUMBITS-1:0] a_r;
    logic [NUMBITS-1:0] b_r;
    logic               cin_r;

    logic                 valid_s     [NSTAGES];
    logic                 carry_s     [NSTAGES];
    logic                 ovf_s       [NSTAGES];
    logic [STAGEBITS-1:0] sum_s       [NSTAGES];
    logic [STAGEBITS-1:0] res_slice_s [NSTAGES];

    // Whole pipeline moves unless a finished result is waiting on the consumer.
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    // Subtract as A + ~B + 1: invert B here, the +1 is the stage-0 carry-in.
    assign b_eff_s = (op == OP_SUB) ? ~B : B;

    // Input capture register; payload only loads on an accepted operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_valid_r <= 1'b0;
            a_r        <= {NUMBITS{1'b0}};
            b_r        <= {NUMBITS{1'b0}};
            cin_r      <= 1'b0;
        end else if (advance_s) begin
            in_valid_r <= in_valid;
            if (in_valid) begin
                a_r   <= A;
                b_r   <= b_eff_s;
                cin_r <= op;
            end
        end
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        logic [STAGEBITS-1:0] a_stage_s;
        logic [STAGEBITS-1:0] b_stage_s;
        logic                 valid_stage_s;
        logic                 cin_stage_s;

        if (k == 0) begin : g_first
            assign a_stage_s     = a_r[STAGEBITS-1:0];
            assign b_stage_s     = b_r[STAGEBITS-1:0];
            assign valid_stage_s = in_valid_r;
            assign cin_stage_s   = cin_r;
        end else begin : g_upper
            logic [STAGEBITS-1:0] a_dly_r [k];
            logic [STAGEBITS-1:0] b_dly_r [k];

            // Operand skew: slice k waits k cycles for the lower carries.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int j = 0; j < k; j++) begin
                        a_dly_r[j] <= {STAGEBITS{1'b0}};
                        b_dly_r[j] <= {STAGEBITS{1'b0}};
                    end
                end else if (advance_s) begin
                    a_dly_r[0] <= a_r[k*STAGEBITS +: STAGEBITS];
                    b_dly_r[0] <= b_r[k*STAGEBITS +: STAGEBITS];
                    for (int j = 1; j < k; j++) begin
                        a_dly_r[j] <= a_dly_r[j-1];
                        b_dly_r[j] <= b_dly_r[j-1];
                    end
                end
            end

            assign a_stage_s     = a_dly_r[k-1];
            assign b_stage_s     = b_dly_r[k-1];
            assign valid_stage_s = valid_s[k-1];
            assign cin_stage_s   = carry_s[k-1];
        end

        adder_slice_stage #(
            .STAGEBITS (STAGEBITS)
        ) u_slice (
            .clk     (clk),
            .reset   (reset),
            .advance (advance_s),
            .valid   (valid_stage_s),
            .cin     (cin_stage_s),
            .a       (a_stage_s),
            .b       (b_stage_s),
            .valid_r (valid_s[k]),
            .cout_r  (carry_s[k]),
            .ovf_r   (ovf_s[k]),
            .sum_r   (sum_s[k])
        );

        if (k < NSTAGES - 1) begin : g_deskew
            localparam int DEPTH = NSTAGES - 1 - k;
            logic [STAGEBITS-1:0] dsk_r [DEPTH];

            // Result deskew: hold slice k until the top slice is finished.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        dsk_r[j] <= {STAGEBITS{1'b0}};
                    end
                end else if (advance_s) begin
                    dsk_r[0] <= sum_s[k];
                    for (int j = 1; j < DEPTH; j++) begin
                        dsk_r[j] <= dsk_r[j-1];
                    end
                end
            end

            assign res_slice_s[k] = dsk_r[DEPTH-1];
        end else begin : g_top_slice
            assign res_slice_s[k] = sum_s[k];
        end
    end

    // Reassemble the aligned result slices.
    always_comb begin
        result = {NUMBITS{1'b0}};
        for (int k = 0; k < NSTAGES; k++) begin
            result[k*STAGEBITS +: STAGEBITS] = res_slice_s[k];
        end
    end

    assign out_valid = valid_s[NSTAGES-1];
    assign carryout  = carry_s[NSTAGES-1];
    assign overflow  = ovf_s[NSTAGES-1];

endmodule : pipelined_carry_adder

// File: tb/tb_pipelined_carry_adder.sv
module tb_pipelined_carry_adder;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        o;
        logic [63:0] r;
        logic        c;
        logic        v;
    } vec_t;

    typedef struct {
        logic [63:0] r;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid64, in_ready64, op64, out_valid64, out_ready64;
    logic        carryout64, overflow64;
    logic [63:0] a64, b64, result64;

    logic        in_valid8, in_ready8, op8, out_valid8, out_ready8;
    logic        carryout8, overflow8;
    logic [7:0]  a8, b8, result8;

    int checks = 0;
    int errors = 0;

    exp_t q64[$];
    exp_t q8[$];
    logic        stall64 = 1'b0, stall8 = 1'b0;
    logic [63:0] hold_r64, hold_r8;
    logic        hold_c64, hold_v64, hold_c8, hold_v8;

    vec_t t64 [7];
    vec_t t8  [7];

    always #5 clk = ~clk;

    pipelined_carry_adder #(.NUMBITS(64), .STAGEBITS(16)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .A(a64), .B(b64), .op(op64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .result(result64), .carryout(carryout64), .overflow(overflow64)
    );

    pipelined_carry_adder #(.NUMBITS(8), .STAGEBITS(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .op(op8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .carryout(carryout8), .overflow(overflow8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain n-bit arithmetic on the operand values.
    function automatic void model(input logic [63:0] a_in, input logic [63:0] b_in, input logic o,
                                  input int n, output logic [63:0] r, output logic c, output logic v);
        logic [63:0] mask, a, b;
        logic [64:0] s;
        mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (o) begin
            s = {1'b0, a} - {1'b0, b};
            r = s[63:0] & mask;
            c = (a >= b);
            v = (a[n-1] != b[n-1]) && (r[n-1] != a[n-1]);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            r = s[63:0] & mask;
            c = s[n];
            v = (a[n-1] == b[n-1]) && (r[n-1] != a[n-1]);
        end
    endfunction

    // Scoreboards: push on acceptance, pop and compare on output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q64.delete();
            stall64 <= 1'b0;
        end else begin
            if (stall64) begin
                chk("hold_valid64", out_valid64, 64'd1);
                chk("hold_result64", result64, hold_r64);
                chk("hold_carry64", carryout64, hold_c64);
                chk("hold_ovf64", overflow64, hold_v64);
            end
            if (in_valid64 && in_ready64) begin
                model(a64, b64, op64, 64, e.r, e.c, e.v);
                q64.push_back(e);
            end
            if (out_valid64 && out_ready64) begin
                if (q64.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out64 actual=%h expected=no_output", result64);
                end else begin
                    e = q64.pop_front();
                    chk("result64", result64, e.r);
                    chk("carry64", carryout64, e.c);
                    chk("ovf64", overflow64, e.v);
                end
            end
            stall64  <= out_valid64 && !out_ready64;
            hold_r64 <= result64;
            hold_c64 <= carryout64;
            hold_v64 <= overflow64;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q8.delete();
            stall8 <= 1'b0;
        end else begin
            if (stall8) begin
                chk("hold_valid8", out_valid8, 64'd1);
                chk("hold_result8", result8, hold_r8);
                chk("hold_carry8", carryout8, hold_c8);
                chk("hold_ovf8", overflow8, hold_v8);
            end
            if (in_valid8 && in_ready8) begin
                model({56'd0, a8}, {56'd0, b8}, op8, 8, e.r, e.c, e.v);
                q8.push_back(e);
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out8 actual=%h expected=no_output", result8);
                end else begin
                    e = q8.pop_front();
                    chk("result8", result8, e.r);
                    chk("carry8", carryout8, e.c);
                    chk("ovf8", overflow8, e.v);
                end
            end
            stall8  <= out_valid8 && !out_ready8;
            hold_r8 <= {56'd0, result8};
            hold_c8 <= carryout8;
            hold_v8 <= overflow8;
        end
    end

    task automatic drive(input bit w8, input logic [63:0] a, input logic [63:0] b,
                         input logic o, input logic vld);
        if (w8) begin
            in_valid8 = vld; a8 = a[7:0]; b8 = b[7:0]; op8 = o;
        end else begin
            in_valid64 = vld; a64 = a; b64 = b; op64 = o;
        end
    endtask

    // Present one op (entered just after a rising edge) and hold it until accepted.
    task automatic put(input bit w8, input logic [63:0] a, input logic [63:0] b, input logic o);
        bit ok;
        ok = 1'b0;
        drive(w8, a, b, o, 1'b1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((w8 ? in_ready8 : in_ready64) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low expected=in_ready_high");
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] x;
        case ($urandom_range(0, 4))
            0:       x = 64'hFFFF_FFFF_FFFF_FFFF;
            1:       x = 64'h8000_0000_0000_0000;
            2:       x = 64'h7FFF_FFFF_FFFF_FFFF;
            default: x = {$urandom, $urandom};
        endcase
        return x;
    endfunction

    task automatic stream(input bit w8, input int n);
        logic [63:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = rnd_operand();
            b = rnd_operand();
            put(w8, a, b, 1'($urandom_range(0, 1)));
        end
        drive(w8, 64'd0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic run_vec(input bit w8, input vec_t v);
        int n;
        n = 0;
        put(w8, v.a, v.b, v.o);
        drive(w8, 64'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if ((w8 ? out_valid8 : out_valid64) === 1'b1) break;
        end
        chk(w8 ? "vec_latency8" : "vec_latency64", 64'(n), w8 ? 64'd1 : 64'd4);
        chk(w8 ? "vec_result8" : "vec_result64", w8 ? {56'd0, result8} : result64, v.r);
        chk(w8 ? "vec_carry8" : "vec_carry64", w8 ? carryout8 : carryout64, v.c);
        chk(w8 ? "vec_ovf8" : "vec_ovf64", w8 ? overflow8 : overflow64, v.v);
    endtask

    // Eight ops on eight consecutive edges; results must be contiguous.
    task automatic back_to_back(input bit w8);
        int lat, cnt, first, last;
        lat = w8 ? 1 : 4;
        cnt = 0; first = -1; last = -1;
        drive(w8, rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), 1'b1);
        for (int c = 1; c <= 8 + lat + 3; c++) begin
            @(posedge clk);
            #1;
            if (c < 8) drive(w8, rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), 1'b1);
            else drive(w8, 64'd0, 64'd0, 1'b0, 1'b0);
            if ((w8 ? out_valid8 : out_valid64) === 1'b1) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("b2b_count", 64'(cnt), 64'd8);
        chk("b2b_first", 64'(first), 64'(lat + 1));
        chk("b2b_last", 64'(last), 64'(lat + 8));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        t64[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        t64[1] = '{64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0};
        t64[2] = '{64'h3, 64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        t64[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        t64[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        t64[5] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        t64[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        t8[0]  = '{64'hFF, 64'h01, 1'b0, 64'h00, 1'b1, 1'b0};
        t8[1]  = '{64'hD5, 64'h64, 1'b0, 64'h39, 1'b1, 1'b0};
        t8[2]  = '{64'h0B, 64'h0B, 1'b0, 64'h16, 1'b0, 1'b0};
        t8[3]  = '{64'h05, 64'h03, 1'b1, 64'h02, 1'b1, 1'b0};
        t8[4]  = '{64'h03, 64'h05, 1'b1, 64'hFE, 1'b0, 1'b0};
        t8[5]  = '{64'h7F, 64'h01, 1'b0, 64'h80, 1'b0, 1'b1};
        t8[6]  = '{64'h80, 64'h01, 1'b1, 64'h7F, 1'b1, 1'b1};

        reset = 1'b1;
        out_ready64 = 1'b1;
        out_ready8  = 1'b1;
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        drive(1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid64", out_valid64, 64'd0);
        chk("rst_result64", result64, 64'd0);
        chk("rst_carry64", carryout64, 64'd0);
        chk("rst_ovf64", overflow64, 64'd0);
        chk("rst_out_valid8", out_valid8, 64'd0);
        chk("rst_result8", result8, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready64", in_ready64, 64'd1);
        chk("rst_in_ready8", in_ready8, 64'd1);

        for (int i = 0; i < 7; i++) run_vec(1'b0, t64[i]);
        for (int i = 0; i < 7; i++) run_vec(1'b1, t8[i]);

        back_to_back(1'b0);
        back_to_back(1'b1);

        // Consumer stalls for three cycles while the 64-bit pipe is full.
        fork
            stream(1'b0, 12);
            begin
                repeat (7) @(posedge clk);
                #1;
                out_ready64 = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready64", in_ready64, 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready64 = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("drain64", 64'(q64.size()), 64'd0);

        // Random consumer back-pressure on the single-stage variant.
        fork
            stream(1'b1, 30);
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    out_ready8 = 1'($urandom_range(0, 1));
                end
                out_ready8 = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("drain8", 64'(q8.size()), 64'd0);

        // Reset while the first result is visible and three more are in flight.
        for (int i = 0; i < 4; i++) put(1'b0, rnd_operand(), rnd_operand(), 1'b0);
        drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("midrst_pre_valid", out_valid64, 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", out_valid64, 64'd0);
        chk("midrst_result", result64, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid64 === 1'b1) seen++;
        end
        chk("midrst_no_ghost", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipelined_carry_adder
